// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner and instruction fetch sequencer (optional PC_ALIGN_CHECK_EN)
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [63:0]         imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_data,
    output logic [31:0]         instruction,
    output logic                instr_valid,
    input  logic [1:0]          ps,
    input  logic [63:0]         k,
    input  logic [63:0]         reg_a,
    input  logic                exec_stall,
    output logic [63:0]         pc,
    output logic [63:0]         pc_plus4,
    output logic [RETIRE_W-1:0] retire_count,
    output logic                fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc_target;
    logic        advance;
    logic        misaligned;
    logic        take_fault;
    logic        commit;
    logic        capture;

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    // Candidate next PC; ps=00 keeps the current PC so the instruction repeats.
    always_comb begin
        pc_target = pc;
        case (ps)
            2'b01:   pc_target = pc + 64'd4;
            2'b10:   pc_target = reg_a;
            2'b11:   pc_target = pc + (k << 2);
            default: pc_target = pc;
        endcase
    end

    assign advance = (state == S_EXEC) && !exec_stall && (ps != 2'b00);

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = ps[1] && (pc_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign take_fault = advance && misaligned;
    assign commit     = advance && !misaligned;
    assign capture    = (state == S_FETCH) && imem_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (imem_valid) state_next = S_EXEC;
            S_EXEC: begin
                if (take_fault) begin
                    state_next = S_FAULT;
                end else if (commit) begin
                    state_next = S_FETCH;
                end
            end
`ifdef PC_ALIGN_CHECK_EN
            S_FAULT: state_next = S_FAULT;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fault       = 1'b0;
        case (state)
            S_FETCH: imem_req    = 1'b1;
            S_EXEC:  instr_valid = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            S_FAULT: fault       = 1'b1;
`endif
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
                fault       = 1'b0;
            end
        endcase
    end

    // Datapath registers: PC, held instruction and retirement counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= RESET_PC;
            instruction  <= 32'h0;
            retire_count <= '0;
        end else begin
            if (capture) begin
                instruction <= imem_data;
            end
            if (commit) begin
                pc           <= pc_target;
                retire_count <= retire_count + RETIRE_ONE;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + 64'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed plus randomized bench for pc_fetch_unit against a behavioural PC model
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [1:0]  ps = 2'b00;
    logic [63:0] k = 64'h0;
    logic [63:0] reg_a = 64'h0;
    logic        exec_stall = 1'b0;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic [3:0]  retire_count;
    logic        fault;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] m_pc;
    int          m_ret;

    pc_fetch_unit #(.RESET_PC(64'h100), .RETIRE_W(4)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .instruction(instruction), .instr_valid(instr_valid),
        .ps(ps), .k(k), .reg_a(reg_a), .exec_stall(exec_stall),
        .pc(pc), .pc_plus4(pc_plus4), .retire_count(retire_count), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input int lat, input logic [31:0] data);
        for (int i = 0; i < lat; i++) begin
            chk("fetch_req", 64'(imem_req), 64'd1);
            chk("fetch_addr", imem_addr, m_pc);
            chk("fetch_iv", 64'(instr_valid), 64'd0);
            step;
        end
        chk("fetch_req_last", 64'(imem_req), 64'd1);
        chk("fetch_addr_last", imem_addr, m_pc);
        imem_valid = 1'b1;
        imem_data  = data;
        step;
        imem_valid = 1'b0;
        imem_data  = $urandom;
        chk("exec_iv", 64'(instr_valid), 64'd1);
        chk("exec_instr", 64'(instruction), 64'(data));
        chk("exec_req", 64'(imem_req), 64'd0);
    endtask

    task automatic do_exec(input int stalls, input int passes, input logic [1:0] fps,
                           input logic [63:0] fk, input logic [63:0] fa, input logic [31:0] data);
        logic [63:0] t;
        for (int i = 0; i < stalls; i++) begin
            exec_stall = 1'b1;
            ps = fps; k = fk; reg_a = fa;
            step;
            chk("stall_iv", 64'(instr_valid), 64'd1);
            chk("stall_pc", pc, m_pc);
            chk("stall_ret", 64'(retire_count), 64'(m_ret));
            chk("stall_instr", 64'(instruction), 64'(data));
        end
        exec_stall = 1'b0;
        for (int i = 0; i < passes; i++) begin
            ps = 2'b00; k = {$urandom, $urandom}; reg_a = {$urandom, $urandom};
            step;
            chk("pass_iv", 64'(instr_valid), 64'd1);
            chk("pass_pc", pc, m_pc);
            chk("pass_ret", 64'(retire_count), 64'(m_ret));
            chk("pass_instr", 64'(instruction), 64'(data));
        end
        ps = fps; k = fk; reg_a = fa;
        case (fps)
            2'b01:   t = m_pc + 64'd4;
            2'b10:   t = fa;
            default: t = m_pc + fk * 4;
        endcase
        step;
        ps = 2'b00;
`ifdef PC_ALIGN_CHECK_EN
        if (fps[1] && t[1:0] != 2'b00) begin
            chk("fault_set", 64'(fault), 64'd1);
            chk("fault_req", 64'(imem_req), 64'd0);
            chk("fault_iv", 64'(instr_valid), 64'd0);
            chk("fault_pc", pc, m_pc);
            chk("fault_ret", 64'(retire_count), 64'(m_ret));
            return;
        end
`endif
        m_pc  = t;
        m_ret = (m_ret + 1) % 16;
        chk("next_pc", pc, m_pc);
        chk("next_plus4", pc_plus4, m_pc + 64'd4);
        chk("next_ret", 64'(retire_count), 64'(m_ret));
        chk("next_req", 64'(imem_req), 64'd1);
        chk("next_iv", 64'(instr_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        step;
        step;
        chk("rst_pc", pc, 64'h100);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_iv", 64'(instr_valid), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_ret", 64'(retire_count), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_plus4", pc_plus4, 64'h104);
        reset = 1'b0;
        step;
        m_pc = 64'h100;
        m_ret = 0;

        do_fetch(3, 32'h8B020020);
        do_exec(0, 0, 2'b01, 64'h0, 64'h0, 32'h8B020020);
        chk("first_fetch_addr", imem_addr, 64'h104);
        chk("first_retire", 64'(retire_count), 64'd1);

        d = $urandom;
        do_fetch(2, d);
        do_exec(0, 1, 2'b01, 64'h0, 64'h0, d);

        d = $urandom;
        do_fetch(1, d);
        do_exec(0, 0, 2'b10, 64'h0, 64'h200, d);
        d = $urandom;
        do_fetch(1, d);
        do_exec(0, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, d);
        chk("k_negative", imem_addr, 64'h1F8);

        d = $urandom;
        do_fetch(0, d);
        do_exec(0, 0, 2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, d);
        d = $urandom;
        do_fetch(1, d);
        do_exec(0, 0, 2'b01, 64'h0, 64'h0, d);
        chk("pc_wrap", pc, 64'h0);

        d = $urandom;
        do_fetch(1, d);
        do_exec(2, 0, 2'b10, 64'h0, 64'h4000, d);
        chk("stall_then_jump", pc, 64'h4000);

        // Reset while fetching; a late imem_valid must be ignored.
        reset = 1'b1;
        step;
        reset = 1'b0;
        imem_valid = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        chk("midrst_instr", 64'(instruction), 64'd0);
        chk("midrst_req", 64'(imem_req), 64'd0);
        chk("midrst_pc", pc, 64'h100);
        step;
        imem_valid = 1'b0;
        chk("late_valid_req", 64'(imem_req), 64'd1);
        chk("late_valid_iv", 64'(instr_valid), 64'd0);
        chk("late_valid_instr", 64'(instruction), 64'd0);
        m_pc = 64'h100;
        m_ret = 0;

        for (int n = 0; n < 24; n++) begin
            logic [1:0] rps;
            d = $urandom;
            rps = 2'($urandom_range(1, 3));
            do_fetch($urandom_range(0, 3), d);
            do_exec($urandom_range(0, 2), $urandom_range(0, 1), rps,
                    {$urandom, $urandom}, {$urandom, $urandom} & ~64'h3, d);
        end

        d = $urandom;
        do_fetch(1, d);
        do_exec(0, 0, 2'b10, 64'h0, 64'h4002, d);
`ifdef PC_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            imem_valid = 1'b1;
            step;
            chk("fault_sticky", 64'(fault), 64'd1);
            chk("fault_sticky_req", 64'(imem_req), 64'd0);
            chk("fault_sticky_pc", pc, m_pc);
        end
        imem_valid = 1'b0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("fault_cleared", 64'(fault), 64'd0);
        chk("fault_rst_pc", pc, 64'h100);
`else
        chk("misaligned_addr", imem_addr, 64'h4002);
        chk("no_fault", 64'(fault), 64'd0);
        d = $urandom;
        do_fetch(0, d);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
